multicycle_seq: RTL
===================

# multicycle_seq

Multi-cycle instruction sequencer, parametrised in XLEN, reset vector and bus timeout, that steps the existing datapath (CU, Reg_File, ALU, PC_update, csr_reg) through FETCH/DECODE/EXEC/MEM/WB phases. It replaces the combinational instruction and data memories with request/grant/response bus handshakes, and adds wait-state tolerance, trap detection and cycle/instret counters. It sits at the core top between the datapath and the bus fabric.

## Interface
- XLEN, 32, datapath and address width
- RESET_PC, 0, PC value loaded at reset
- TIMEOUT, 255, max wait cycles per bus phase; 0 disables timeout
- CNT_W, 64, width of cycle/instret counters
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ibus_req  out  1  fetch request, held until grant
- ibus_addr  out  XLEN  fetch address (= pc)
- ibus_gnt  in  1  fetch request accepted
- ibus_rvalid  in  1  fetch data valid
- ibus_rdata  in  32  fetched instruction
- dbus_req  out  1  data request, held until grant
- dbus_we  out  1  1 = store
- dbus_gnt  in  1  data request accepted
- dbus_rvalid  in  1  load data / store ack valid
- next_pc  in  XLEN  from PC_update, sampled at WB
- pc  out  XLEN  architectural PC
- ir  out  32  latched instruction register
- exec_en  out  1  one-cycle pulse in EXEC; gates CSR write and ALU result latch
- mem_phase  out  1  high in MEM/MEM_WAIT
- reg_write  out  1  one-cycle pulse in WB for writing classes with rd≠0
- halted  out  1  sequencer in TRAP
- trap_cause  out  3  0 none, 1 illegal, 2 bus timeout, 3 ecall/ebreak, 4 misaligned next_pc
- cycle_count  out  CNT_W  cycles since reset while not halted
- instret_count  out  CNT_W  retired instructions

## Operation
- States: FETCH, FETCH_WAIT, DECODE, EXEC, MEM, MEM_WAIT, WB, TRAP.
- FETCH: ibus_req=1, ibus_addr=pc. On gnt&rvalid latch ir → DECODE; gnt only → FETCH_WAIT.
- FETCH_WAIT: req=0; on rvalid latch ir → DECODE.
- DECODE: classify ir[6:0]; ir[1:0]≠2'b11 or unknown opcode → TRAP cause 1. SYSTEM with funct3=0 → TRAP cause 3. Otherwise → EXEC.
- EXEC: exec_en=1. LOAD/STORE → MEM, else → WB.
- MEM / MEM_WAIT: same handshake as fetch on dbus; dbus_we=1 for STORE. Response → WB.
- WB: reg_write per class (OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD, CSR; not STORE/BRANCH). If next_pc[1:0]≠0 → TRAP cause 4, no retire, no reg_write. Else pc←next_pc, instret+1, → FETCH.
- Timeout: counter cleared on entry to FETCH/MEM; counts each cycle in FETCH/FETCH_WAIT/MEM/MEM_WAIT. Reaching TIMEOUT without response → TRAP cause 2.
- TRAP: absorbing until reset. No bus requests, pc holds faulting instruction address, counters frozen.
- Simultaneous gnt and rvalid is legal (zero-wait bus). rvalid without a prior or same-cycle gnt is ignored.

## Timing
- Reset values: pc=RESET_PC, ir=32'h00000013 (NOP), all strobes 0, halted=0, trap_cause=0, counters 0, state FETCH.
- Reset asserts immediately; bus slaves share rst, so no stale responses exist after release.
- Zero-wait latency: ALU/branch/jump/CSR 4 cycles (FETCH, DECODE, EXEC, WB); load/store 5 cycles. Each wait state adds 1 cycle.
- ibus_addr and dbus_we are stable for the entire request phase.
- Counters wrap modulo 2^CNT_W.

## Structure
- Package mc_pkg: state enum, RV32 opcode constants, trap-cause codes, NOP constant.
- Sub-module mc_opclass: combinational ir → {legal, is_load, is_store, writes_rd, is_ecall}.
- Bus-phase logic is shared between FETCH and MEM; single timeout counter of width $clog2(TIMEOUT+1).

## Test plan
- ADDI x1,x0,5 on a zero-wait bus → reg_write pulse in cycle 4, pc 0→4, instret=1 after 4 cycles.
- LW with 3-cycle dbus latency → dbus_req held until gnt, WB 3 cycles later, total 8 cycles.
- Fetch never answered, TIMEOUT=8 → halted=1, trap_cause=2 after 8 wait cycles, ibus_req=0 thereafter.
- Word 32'h00000000 fetched → trap_cause=1, pc unchanged, no reg_write, instret unchanged.
- JALR producing next_pc=0x102 → trap_cause=4, no reg_write, pc holds JALR address.
- rst pulled low in MEM_WAIT → all outputs at reset values in the same cycle; refetch from RESET_PC after release.

Source files
------------

// File: rtl/multicycle_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mc_pkg
// Brief    : Shared types and constants for the multi-cycle sequencer:
//            FSM state encoding, RV32 major opcodes, trap-cause codes,
//            the reset-time instruction word and the opcode class record.
// Revision : 1.0 - initial release
// ============================================================================
package mc_pkg;

    // Sequencer phases
    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_DECODE     = 3'd2,
        S_EXEC       = 3'd3,
        S_MEM        = 3'd4,
        S_MEM_WAIT   = 3'd5,
        S_WB         = 3'd6,
        S_TRAP       = 3'd7
    } state_t;

    // RV32 major opcodes (ir[6:0])
    localparam logic [6:0] c_opc_load     = 7'b0000011;
    localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
    localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
    localparam logic [6:0] c_opc_auipc    = 7'b0010111;
    localparam logic [6:0] c_opc_store    = 7'b0100011;
    localparam logic [6:0] c_opc_op       = 7'b0110011;
    localparam logic [6:0] c_opc_lui      = 7'b0110111;
    localparam logic [6:0] c_opc_branch   = 7'b1100011;
    localparam logic [6:0] c_opc_jalr     = 7'b1100111;
    localparam logic [6:0] c_opc_jal      = 7'b1101111;
    localparam logic [6:0] c_opc_system   = 7'b1110011;

    // Trap causes reported on trap_cause
    localparam logic [2:0] c_trap_none     = 3'd0;
    localparam logic [2:0] c_trap_illegal  = 3'd1;
    localparam logic [2:0] c_trap_timeout  = 3'd2;
    localparam logic [2:0] c_trap_ecall    = 3'd3;
    localparam logic [2:0] c_trap_misalign = 3'd4;

    // ADDI x0,x0,0 - the instruction register holds this out of reset
    localparam logic [31:0] c_nop = 32'h0000_0013;

    // Decoded instruction class
    typedef struct packed {
        logic legal;
        logic is_load;
        logic is_store;
        logic writes_rd;
        logic is_ecall;
    } opclass_t;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/multicycle_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : multicycle_seq_if
// Brief     : Instruction and data bus handshakes between the sequencer
//             (master) and the bus fabric (slave). Requests are held until
//             granted; responses arrive on rvalid in or after the grant cycle.
// Revision  : 1.0 - initial release
// ============================================================================
interface multicycle_seq_if #(
    parameter int unsigned XLEN = 32
);
    // instruction bus
    logic            ibus_req;
    logic [XLEN-1:0] ibus_addr;
    logic            ibus_gnt;
    logic            ibus_rvalid;
    logic [31:0]     ibus_rdata;

    // data bus (address and write data come from the datapath)
    logic            dbus_req;
    logic            dbus_we;
    logic            dbus_gnt;
    logic            dbus_rvalid;

    modport master (
        output ibus_req,
        output ibus_addr,
        input  ibus_gnt,
        input  ibus_rvalid,
        input  ibus_rdata,
        output dbus_req,
        output dbus_we,
        input  dbus_gnt,
        input  dbus_rvalid
    );

    modport slave (
        input  ibus_req,
        input  ibus_addr,
        output ibus_gnt,
        output ibus_rvalid,
        output ibus_rdata,
        input  dbus_req,
        input  dbus_we,
        output dbus_gnt,
        output dbus_rvalid
    );

endinterface : multicycle_seq_if
`default_nettype wire

// File: rtl/multicycle_seq_opclass.sv
`default_nettype none
// ============================================================================
// Module   : mc_opclass
// Brief    : Combinational classifier of the latched instruction word into
//            legality, memory direction, register-write and ecall/ebreak.
// Revision : 1.0 - initial release
// ============================================================================
module mc_opclass
    import mc_pkg::*;
(
    input  logic [31:0] ir,
    output opclass_t    cls
);

    // Only opcode and funct3 matter for classification
    logic w_unused_ir;
    assign w_unused_ir = ^{ir[31:15], ir[11:7]};

    // Opcode lookup; anything not listed (including ir[1:0] != 2'b11) is illegal
    always_comb begin
        cls = '0;
        case (ir[6:0])
            c_opc_lui, c_opc_auipc, c_opc_jal, c_opc_jalr,
            c_opc_op_imm, c_opc_op: begin
                cls.legal     = 1'b1;
                cls.writes_rd = 1'b1;
            end
            c_opc_branch, c_opc_misc_mem: begin
                cls.legal = 1'b1;
            end
            c_opc_load: begin
                cls.legal     = 1'b1;
                cls.is_load   = 1'b1;
                cls.writes_rd = 1'b1;
            end
            c_opc_store: begin
                cls.legal    = 1'b1;
                cls.is_store = 1'b1;
            end
            c_opc_system: begin
                cls.legal = 1'b1;
                // funct3 == 0 is ecall/ebreak, everything else is a CSR op
                if (ir[14:12] == 3'b000) begin
                    cls.is_ecall = 1'b1;
                end else begin
                    cls.writes_rd = 1'b1;
                end
            end
            default: begin
                cls = '0;
            end
        endcase
    end

endmodule : mc_opclass
`default_nettype wire

// File: rtl/multicycle_seq.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_seq
// Brief    : Multi-cycle instruction sequencer. Steps the datapath through
//            FETCH/DECODE/EXEC/MEM/WB over request/grant/response buses,
//            detects traps (illegal, bus timeout, ecall/ebreak, misaligned
//            next_pc) and keeps cycle and instret counters.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_seq
    import mc_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 255,
    parameter int unsigned     CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_seq_if.master bus,
    input  logic [XLEN-1:0]  next_pc,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      ir,
    output logic             exec_en,
    output logic             mem_phase,
    output logic             reg_write,
    output logic             halted,
    output logic [2:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    // A zero TIMEOUT disables the watchdog; keep the counter one bit wide then
    localparam int unsigned c_tmo_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last =
        c_tmo_w'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [2:0]         trap_cause_q, trap_cause_d;
    logic [c_tmo_w-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    opclass_t           cls;

    logic               w_data_phase;
    logic               w_req_phase;
    logic               w_gnt;
    logic               w_rvalid;
    logic               w_done;
    logic               w_to_wait;
    logic               w_expire;

    mc_opclass u_opclass (
        .ir  (ir_q),
        .cls (cls)
    );

    // Shared bus-phase view: FETCH/FETCH_WAIT use ibus, MEM/MEM_WAIT use dbus.
    // In the request states a response only counts together with a grant;
    // in the wait states the grant has already happened.
    assign w_data_phase = (state_q == S_MEM) || (state_q == S_MEM_WAIT);
    assign w_req_phase  = (state_q == S_FETCH) || (state_q == S_MEM);
    assign w_gnt        = w_data_phase ? bus.dbus_gnt    : bus.ibus_gnt;
    assign w_rvalid     = w_data_phase ? bus.dbus_rvalid : bus.ibus_rvalid;
    assign w_done       = w_req_phase ? (w_gnt && w_rvalid) : w_rvalid;
    assign w_to_wait    = w_req_phase && w_gnt;
    assign w_expire     = (TIMEOUT != 0) && (tmo_q == c_tmo_last);

    // Next-state, datapath strobes and counter updates
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        trap_cause_d = trap_cause_q;
        tmo_d        = tmo_q;
        instret_d    = instret_q;
        cycle_d      = (state_q == S_TRAP) ? cycle_q : (cycle_q + CNT_W'(1));
        exec_en      = 1'b0;
        reg_write    = 1'b0;

        case (state_q)
            S_FETCH, S_FETCH_WAIT, S_MEM, S_MEM_WAIT: begin
                if (w_done) begin
                    if (w_data_phase) begin
                        state_d = S_WB;
                    end else begin
                        ir_d    = bus.ibus_rdata;
                        state_d = S_DECODE;
                    end
                end else if (w_expire) begin
                    state_d      = S_TRAP;
                    trap_cause_d = c_trap_timeout;
                end else begin
                    if (TIMEOUT != 0) begin
                        tmo_d = tmo_q + c_tmo_w'(1);
                    end
                    if (w_to_wait) begin
                        state_d = w_data_phase ? S_MEM_WAIT : S_FETCH_WAIT;
                    end
                end
            end

            S_DECODE: begin
                if (!cls.legal) begin
                    state_d      = S_TRAP;
                    trap_cause_d = c_trap_illegal;
                end else if (cls.is_ecall) begin
                    state_d      = S_TRAP;
                    trap_cause_d = c_trap_ecall;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                exec_en = 1'b1;
                if (cls.is_load || cls.is_store) begin
                    state_d = S_MEM;
                    tmo_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end

            S_WB: begin
                // A misaligned target traps before anything architectural changes
                if (next_pc[1:0] != 2'b00) begin
                    state_d      = S_TRAP;
                    trap_cause_d = c_trap_misalign;
                end else begin
                    reg_write = cls.writes_rd && (ir_q[11:7] != 5'd0);
                    pc_d      = next_pc;
                    instret_d = instret_q + CNT_W'(1);
                    tmo_d     = '0;
                    state_d   = S_FETCH;
                end
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and architectural registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= c_nop;
            trap_cause_q <= c_trap_none;
            tmo_q        <= '0;
            cycle_q      <= '0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            trap_cause_q <= trap_cause_d;
            tmo_q        <= tmo_d;
            cycle_q      <= cycle_d;
            instret_q    <= instret_d;
        end
    end

    // The fetch request is held off while reset is asserted so nothing is
    // advertised to the fabric before release.
    assign bus.ibus_req  = rst && (state_q == S_FETCH);
    assign bus.ibus_addr = pc_q;
    assign bus.dbus_req  = (state_q == S_MEM);
    assign bus.dbus_we   = w_data_phase && cls.is_store;

    assign pc            = pc_q;
    assign ir            = ir_q;
    assign mem_phase     = w_data_phase;
    assign halted        = (state_q == S_TRAP);
    assign trap_cause    = trap_cause_q;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;

endmodule : multicycle_seq
`default_nettype wire
